simmem_wresp_bank: RTL and testbench

SIMMEM_WRESP_BANK -- requirements
Module: simmem_wresp_bank

---
 rtl/simmem_pkg.sv | 15 +
 rtl/simmem_release_arbiter.sv | 80 ++++++++
 rtl/simmem_wresp_bank.sv | 106 ++++++++++
 tb/tb_simmem_wresp_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared types for the simulated-memory write-response path.
// No logic; widths derive from WriteRespBankCapacity.
package simmem_pkg;

    localparam int unsigned WriteRespBankCapacity = 4;
    localparam int unsigned WriteIidWidth         = $clog2(WriteRespBankCapacity);

    typedef logic [WriteIidWidth-1:0] write_iid_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } wresp_t;

endpackage

// File: rtl/simmem_release_arbiter.sv
// Picks one eligible slot for release; lowest-index, or round-robin with SIMMEM_WRESP_RELEASE_RR_EN.
// Latency: combinational pick, registered lock and round-robin pointer.
// Backpressure: an offered pick stays locked until out_ready_i accepts it.
module simmem_release_arbiter #(
    parameter int unsigned Capacity = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [Capacity-1:0]         eligible_i,
    input  logic                        out_ready_i,
    output logic                        sel_valid_o,
    output logic [$clog2(Capacity)-1:0] sel_idx_o,
    output logic [Capacity-1:0]         sel_onehot_o
);

    localparam int unsigned IdxW = $clog2(Capacity);

    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            pick_vld;
    logic [IdxW-1:0] pick_idx;

`ifdef SIMMEM_WRESP_RELEASE_RR_EN
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] cand;

    // Capacity is a power of two, so the index addition wraps naturally.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < Capacity; i++) begin
            cand = rr_ptr_q + IdxW'(i);
            if (!pick_vld && eligible_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (sel_valid_o && out_ready_i) begin
            rr_ptr_q <= sel_idx_o + IdxW'(1);
        end
    end
`else
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < Capacity; i++) begin
            if (!pick_vld && eligible_i[i]) begin
                pick_vld = 1'b1;
                pick_idx = IdxW'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_valid_o  = lock_q || pick_vld;
        sel_idx_o    = lock_q ? lock_idx_q : pick_idx;
        sel_onehot_o = '0;
        if (sel_valid_o) begin
            sel_onehot_o[sel_idx_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (sel_valid_o) begin
            lock_q     <= !out_ready_i;
            lock_idx_q <= sel_idx_o;
        end
    end

endmodule

// File: rtl/simmem_wresp_bank.sv
// Write-response bank: reserve slot on address, fill from memory, release when enabled (SIMMEM_WRESP_RELEASE_RR_EN selects round-robin).
// Latency: reservation/fill/release take effect on the next edge; grant and output are combinational.
// Backpressure: rsv_ready_o drops when full; out_resp_o held stable while out_ready_i is low.
module simmem_wresp_bank
    import simmem_pkg::*;
#(
    parameter int unsigned Capacity  = simmem_pkg::WriteRespBankCapacity,
    parameter int unsigned RespWidth = $bits(simmem_pkg::wresp_t)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        rsv_valid_i,
    output logic                        rsv_ready_o,
    output logic [$clog2(Capacity)-1:0] rsv_iid_o,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [$clog2(Capacity)-1:0] in_iid_i,
    input  logic [RespWidth-1:0]        in_resp_i,
    input  logic [Capacity-1:0]         release_en_onehot_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [RespWidth-1:0]        out_resp_o,
    output logic [Capacity-1:0]         released_addr_onehot_o
);

    localparam int unsigned IidW = $clog2(Capacity);

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_RESERVED = 2'd1,
        SLOT_FILLED   = 2'd2
    } slot_state_e;

    slot_state_e          state_q [Capacity];
    logic [RespWidth-1:0] pay_q   [Capacity];

    logic [Capacity-1:0] eligible;
    logic                rsv_fire;
    logic                fill_ok;
    logic                fill_proto_err;
    logic                rel_fire;
    logic                sel_valid;
    logic [IidW-1:0]     sel_idx;
    logic [Capacity-1:0] sel_onehot;

    // A slot released this cycle is still FILLED here, so it cannot be re-granted until next cycle.
    always_comb begin
        rsv_ready_o = 1'b0;
        rsv_iid_o   = '0;
        eligible    = '0;
        for (int i = 0; i < Capacity; i++) begin
            if (!rsv_ready_o && state_q[i] == SLOT_FREE) begin
                rsv_ready_o = 1'b1;
                rsv_iid_o   = IidW'(i);
            end
            eligible[i] = (state_q[i] == SLOT_FILLED) && release_en_onehot_i[i];
        end
    end

    assign in_ready_o     = 1'b1;
    assign rsv_fire       = rsv_valid_i && rsv_ready_o;
    assign fill_ok        = in_valid_i && (state_q[in_iid_i] == SLOT_RESERVED);
    assign fill_proto_err = in_valid_i && !fill_ok;
    assign rel_fire       = sel_valid && out_ready_i;

    cover property (@(posedge clk_i) disable iff (!rst_ni) fill_proto_err);

    simmem_release_arbiter #(
        .Capacity (Capacity)
    ) u_release_arbiter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .eligible_i   (eligible),
        .out_ready_i  (out_ready_i),
        .sel_valid_o  (sel_valid),
        .sel_idx_o    (sel_idx),
        .sel_onehot_o (sel_onehot)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Capacity; i++) begin
                state_q[i] <= SLOT_FREE;
                pay_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < Capacity; i++) begin
                if (rsv_fire && rsv_iid_o == IidW'(i)) begin
                    state_q[i] <= SLOT_RESERVED;
                end
                if (fill_ok && in_iid_i == IidW'(i)) begin
                    state_q[i] <= SLOT_FILLED;
                    pay_q[i]   <= in_resp_i;
                end
                if (rel_fire && sel_onehot[i]) begin
                    state_q[i] <= SLOT_FREE;
                end
            end
        end
    end

    assign out_valid_o            = sel_valid;
    assign out_resp_o             = sel_valid ? pay_q[sel_idx] : '0;
    assign released_addr_onehot_o = rel_fire ? sel_onehot : '0;

endmodule

// File: tb/tb_simmem_wresp_bank.sv
// Bench for simmem_wresp_bank (Capacity=4): directed scenarios then random traffic
// against a slot-level reference model.
module tb_simmem_wresp_bank;
    import simmem_pkg::*;

    localparam int CAP = WriteRespBankCapacity;
    localparam int RW  = $bits(wresp_t);

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             rsv_valid_i;
    logic             rsv_ready_o;
    write_iid_t       rsv_iid_o;
    logic             in_valid_i;
    logic             in_ready_o;
    write_iid_t       in_iid_i;
    logic [RW-1:0]    in_resp_i;
    logic [CAP-1:0]   release_en_onehot_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [RW-1:0]    out_resp_o;
    logic [CAP-1:0]   released_addr_onehot_o;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 free, 1 reserved, 2 filled; m_lock = slot held on the output or -1.
    int            m_state [CAP];
    logic [RW-1:0] m_pay   [CAP];
    int            m_lock;
    int            m_ptr;

    always #5 clk_i = ~clk_i;

    simmem_wresp_bank dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .rsv_valid_i            (rsv_valid_i),
        .rsv_ready_o            (rsv_ready_o),
        .rsv_iid_o              (rsv_iid_o),
        .in_valid_i             (in_valid_i),
        .in_ready_o             (in_ready_o),
        .in_iid_i               (in_iid_i),
        .in_resp_i              (in_resp_i),
        .release_en_onehot_i    (release_en_onehot_i),
        .out_valid_o            (out_valid_o),
        .out_ready_i            (out_ready_i),
        .out_resp_o             (out_resp_o),
        .released_addr_onehot_o (released_addr_onehot_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int j = 0; j < CAP; j++) begin
            m_state[j] = 0;
            m_pay[j]   = '0;
        end
        m_lock = -1;
        m_ptr  = 0;
    endtask

    function automatic int m_first_free();
        for (int j = 0; j < CAP; j++) if (m_state[j] == 0) return j;
        return -1;
    endfunction

    function automatic int m_pick(input logic [CAP-1:0] en);
        int j;
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < CAP; k++) begin
`ifdef SIMMEM_WRESP_RELEASE_RR_EN
            j = (m_ptr + k) % CAP;
`else
            j = k;
`endif
            if (m_state[j] == 2 && en[j]) return j;
        end
        return -1;
    endfunction

    // Compare all outputs against the model for the current inputs, then advance one edge.
    task automatic cycle();
        int f;
        int s;
        #1;
        f = m_first_free();
        s = m_pick(release_en_onehot_i);
        chk("in_ready", in_ready_o, 1);
        chk("rsv_ready", rsv_ready_o, (f >= 0) ? 1 : 0);
        if (f >= 0) chk("rsv_iid", rsv_iid_o, f);
        chk("out_valid", out_valid_o, (s >= 0) ? 1 : 0);
        if (s >= 0) chk("out_resp", out_resp_o, m_pay[s]);
        else        chk("out_resp_idle", out_resp_o, 0);
        chk("released", released_addr_onehot_o, (s >= 0 && out_ready_i) ? (32'd1 << s) : 32'd0);
        if (in_valid_i && m_state[in_iid_i] == 1) begin
            m_state[in_iid_i] = 2;
            m_pay[in_iid_i]   = in_resp_i;
        end
        if (rsv_valid_i && f >= 0) m_state[f] = 1;
        if (s >= 0) begin
            if (out_ready_i) begin
                m_state[s] = 0;
                m_lock     = -1;
                m_ptr      = (s + 1) % CAP;
            end else begin
                m_lock = s;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni              = 1'b0;
        rsv_valid_i         = 1'b0;
        in_valid_i          = 1'b0;
        in_iid_i            = '0;
        in_resp_i           = '0;
        release_en_onehot_i = '0;
        out_ready_i         = 1'b0;
        #1;
        chk("rst_rsv_ready", rsv_ready_o, 1);
        chk("rst_rsv_iid", rsv_iid_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_released", released_addr_onehot_o, 0);
        chk("rst_out_resp", out_resp_o, 0);
        m_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic fill(input int iid, input logic [RW-1:0] val);
        in_valid_i = 1'b1;
        in_iid_i   = write_iid_t'(iid);
        in_resp_i  = val;
        cycle();
        in_valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pick;

        do_reset();

        // Back-to-back reservations grant 0..3, then the bank is full.
        rsv_valid_i = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            #1;
            chk("rsv_seq_iid", rsv_iid_o, i);
            cycle();
        end
        #1;
        chk("rsv_full_ready", rsv_ready_o, 0);
        rsv_valid_i = 1'b0;
        cycle();

        // Single fill/release; the freed slot is the next grant.
        fill(2, 8'h05);
        release_en_onehot_i = 4'b0100;
        out_ready_i         = 1'b1;
        #1;
        chk("rel2_resp", out_resp_o, 8'h05);
        chk("rel2_pulse", released_addr_onehot_o, 4'b0100);
        cycle();
        release_en_onehot_i = '0;
        rsv_valid_i         = 1'b1;
        #1;
        chk("regrant_iid", rsv_iid_o, 2);
        cycle();
        rsv_valid_i = 1'b0;
        out_ready_i = 1'b0;

        // Locked output survives backpressure and release_en dropping.
        fill(1, 8'h11);
        fill(3, 8'h33);
        release_en_onehot_i = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_resp", out_resp_o, 8'h11);
            cycle();
        end
        release_en_onehot_i = 4'b0000;
        #1;
        chk("hold_valid_en_drop", out_valid_o, 1);
        chk("hold_resp_en_drop", out_resp_o, 8'h11);
        cycle();
        out_ready_i = 1'b1;
        #1;
        chk("hold_release", released_addr_onehot_o, 4'b0010);
        cycle();
        #1;
        chk("after_release_valid", out_valid_o, 0);
        cycle();
        out_ready_i = 1'b0;

        // A fill aimed at a FREE slot is dropped.
        do_reset();
        fill(0, 8'h77);
        release_en_onehot_i = 4'b0001;
        #1;
        chk("fill_free_ignored", out_valid_o, 0);
        cycle();
        release_en_onehot_i = '0;

        // All four filled and enabled: released in index order.
        do_reset();
        rsv_valid_i = 1'b1;
        repeat (CAP) cycle();
        rsv_valid_i = 1'b0;
        for (int i = 0; i < CAP; i++) fill(i, RW'(8'hA0 + i));
        release_en_onehot_i = 4'b1111;
        out_ready_i         = 1'b1;
        for (int k = 0; k < CAP; k++) begin
            #1;
            chk("order_rel", released_addr_onehot_o, 32'd1 << k);
            cycle();
        end

        // Slot 3 left pending, slots 0 and 1 refilled, then all enabled.
        release_en_onehot_i = '0;
        rsv_valid_i         = 1'b1;
        repeat (CAP) cycle();
        rsv_valid_i = 1'b0;
        for (int i = 0; i < CAP; i++) fill(i, RW'(8'hC0 + i));
        release_en_onehot_i = 4'b0111;
        repeat (3) cycle();
        release_en_onehot_i = '0;
        out_ready_i         = 1'b0;
        rsv_valid_i         = 1'b1;
        repeat (2) cycle();
        rsv_valid_i = 1'b0;
        fill(0, 8'hB0);
        fill(1, 8'hB1);
        release_en_onehot_i = 4'b1111;
        out_ready_i         = 1'b1;
`ifdef SIMMEM_WRESP_RELEASE_RR_EN
        exp_pick = 32'h8;
`else
        exp_pick = 32'h1;
`endif
        #1;
        chk("refill_pick", released_addr_onehot_o, exp_pick);
        cycle();

        // Reset with two FILLED slots and a valid output drops everything silently.
        out_ready_i = 1'b0;
        cycle();
        #1;
        chk("pre_rst_valid", out_valid_o, 1);
        rst_ni      = 1'b0;
        out_ready_i = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_rsv_ready", rsv_ready_o, 1);
        chk("mid_rst_released", released_addr_onehot_o, 0);
        m_reset();
        @(posedge clk_i);
        #1;
        chk("post_rst_valid", out_valid_o, 0);
        chk("post_rst_released", released_addr_onehot_o, 0);
        rst_ni      = 1'b1;
        out_ready_i = 1'b0;
        cycle();

        // Random traffic, including stray fills to non-reserved slots.
        for (int n = 0; n < 600; n++) begin
            rsv_valid_i         = 1'($urandom_range(0, 1));
            in_valid_i          = 1'($urandom_range(0, 1));
            in_iid_i            = write_iid_t'($urandom_range(0, CAP - 1));
            in_resp_i           = RW'($urandom);
            release_en_onehot_i = CAP'($urandom);
            out_ready_i         = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
